// File: rtl/filesystem_arbiter.sv
// Round-robin front end that multiplexes CHANNELS client ports onto the single
// HPS file-bridge backend, one transaction at a time with timeout and read masking.
module filesystem_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 1023
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic [CHANNELS-1:0]        cli_req,
  input  logic [2*CHANNELS-1:0]      cli_op,
  input  logic [32*CHANNELS-1:0]     cli_fd,
  input  logic [ADDR_W*CHANNELS-1:0] cli_addr,
  input  logic [5*CHANNELS-1:0]      cli_bits,
  input  logic [DATA_W*CHANNELS-1:0] cli_wdata,
  output logic [CHANNELS-1:0]        cli_ack,
  output logic [CHANNELS-1:0]        cli_err,
  output logic [DATA_W-1:0]          cli_rdata,
  output logic                       be_valid,
  output logic [1:0]                 be_op,
  output logic [31:0]                be_fd,
  output logic [ADDR_W-1:0]          be_addr,
  output logic [4:0]                 be_bits,
  output logic [DATA_W-1:0]          be_wdata,
  input  logic                       be_ready,
  input  logic [DATA_W-1:0]          be_rdata,
  input  logic                       be_eof
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] OP_READ = 2'b00;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_rr;
  logic [CW-1:0]       r_grant;
  logic [TW-1:0]       r_cnt;
  logic                r_be_valid;
  logic [1:0]          r_be_op;
  logic [31:0]         r_be_fd;
  logic [ADDR_W-1:0]   r_be_addr;
  logic [4:0]          r_be_bits;
  logic [DATA_W-1:0]   r_be_wdata;
  logic [DATA_W-1:0]   r_res;
  logic                r_res_err;
  logic [CHANNELS-1:0] r_ack;
  logic [CHANNELS-1:0] r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_found;
  logic [CW-1:0]       w_gidx;
  int                  w_cand;
  logic [1:0]          w_sel_op;
  logic [31:0]         w_sel_fd;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [4:0]          w_sel_bits;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_result;
  logic [CW-1:0]       w_rr_next;
  logic                w_timeout;

  // Keep the low `bits` bits of a read word; zero bits selects the full word.
  function automatic logic [DATA_W-1:0] f_mask_rdata(input logic [4:0] bits,
                                                     input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] mask;
    if (bits == 5'd0) mask = '1;
    else              mask = ({{(DATA_W-1){1'b0}}, 1'b1} << bits) - {{(DATA_W-1){1'b0}}, 1'b1};
    return data & mask;
  endfunction

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cand = int'(r_rr) + i;
      if (w_cand >= CHANNELS) w_cand = w_cand - CHANNELS;
      if (!w_found && cli_req[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = CW'(w_cand);
      end
    end
  end

  always_comb begin
    w_sel_op    = cli_op[2*int'(w_gidx) +: 2];
    w_sel_fd    = cli_fd[32*int'(w_gidx) +: 32];
    w_sel_addr  = cli_addr[ADDR_W*int'(w_gidx) +: ADDR_W];
    w_sel_bits  = cli_bits[5*int'(w_gidx) +: 5];
    w_sel_wdata = cli_wdata[DATA_W*int'(w_gidx) +: DATA_W];
    w_result    = (r_be_op == OP_READ && !be_eof) ? f_mask_rdata(r_be_bits, be_rdata) : '0;
    w_rr_next   = (r_grant == CW'(CHANNELS - 1)) ? '0 : r_grant + 1'b1;
    w_timeout   = (r_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_be_valid <= 1'b0;
      r_be_op    <= '0;
      r_be_fd    <= '0;
      r_be_addr  <= '0;
      r_be_bits  <= '0;
      r_be_wdata <= '0;
      r_res      <= '0;
      r_res_err  <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      r_rdata    <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_gidx;
            r_be_op    <= w_sel_op;
            r_be_fd    <= w_sel_fd;
            r_be_addr  <= w_sel_addr;
            r_be_bits  <= w_sel_bits;
            r_be_wdata <= w_sel_wdata;
            r_cnt      <= '0;
            r_be_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          // A completion in the timeout cycle still counts as a success.
          if (be_ready) begin
            r_be_valid <= 1'b0;
            r_res      <= w_result;
            r_res_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_be_valid <= 1'b0;
            r_res      <= '0;
            r_res_err  <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          r_ack[r_grant] <= 1'b1;
          r_err[r_grant] <= r_res_err;
          r_rdata        <= r_res;
          r_rr           <= w_rr_next;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cli_ack   = r_ack;
  assign cli_err   = r_err;
  assign cli_rdata = r_rdata;
  assign be_valid  = r_be_valid;
  assign be_op     = r_be_op;
  assign be_fd     = r_be_fd;
  assign be_addr   = r_be_addr;
  assign be_bits   = r_be_bits;
  assign be_wdata  = r_be_wdata;

endmodule

// File: tb/tb_filesystem_arbiter.sv
// Bench for filesystem_arbiter: vector table, hand-written corner sequences and
// randomized batches against a round-robin/masking reference model.
module tb_filesystem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [2*N-1:0]  op;
  logic [32*N-1:0] fd;
  logic [AW*N-1:0] addr;
  logic [5*N-1:0]  bits;
  logic [DW*N-1:0] wdata;
  logic [N-1:0]    ack, err;
  logic [DW-1:0]   rdata;
  logic            be_valid;
  logic [1:0]      be_op;
  logic [31:0]     be_fd;
  logic [AW-1:0]   be_addr;
  logic [4:0]      be_bits;
  logic [DW-1:0]   be_wdata;
  logic            be_ready;
  logic [DW-1:0]   be_rdata;
  logic            be_eof;

  always #5 clk = ~clk;

  filesystem_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLOCK_50(clk), .reset_n(rst_n),
    .cli_req(req), .cli_op(op), .cli_fd(fd), .cli_addr(addr), .cli_bits(bits),
    .cli_wdata(wdata), .cli_ack(ack), .cli_err(err), .cli_rdata(rdata),
    .be_valid(be_valid), .be_op(be_op), .be_fd(be_fd), .be_addr(be_addr),
    .be_bits(be_bits), .be_wdata(be_wdata), .be_ready(be_ready),
    .be_rdata(be_rdata), .be_eof(be_eof)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_client(input int ch, input logic [1:0] o, input logic [31:0] f,
                            input logic [31:0] a, input logic [4:0] b, input logic [31:0] w);
    op[2*ch +: 2]     = o;
    fd[32*ch +: 32]   = f;
    addr[AW*ch +: AW] = a;
    bits[5*ch +: 5]   = b;
    wdata[DW*ch +: DW] = w;
  endtask

  // Returns at the first falling edge where be_valid is high.
  task automatic wait_valid(output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      waited++;
      if (be_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the falling edge where be_valid was seen; returns at the ack falling edge.
  task automatic serve(input int k, input logic [31:0] rd, input logic eof,
                       output logic [N-1:0] a, output logic [N-1:0] e,
                       output logic [31:0] d, output int edges);
    edges = 0; a = '0; e = '0; d = '0;
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      edges++;
    end
    be_ready = 1'b1; be_rdata = rd; be_eof = eof;
    @(negedge clk);
    edges++;
    be_ready = 1'b0; be_eof = 1'b0; be_rdata = 32'hBAD0_BAD0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      edges++;
      if (ack != '0) begin
        a = ack; e = err; d = rdata;
        break;
      end
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [1:0] o, input logic [4:0] b,
                                              input logic [31:0] d, input logic eof);
    longint m;
    if (o != 2'b00 || eof) return 32'h0;
    m = (b == 5'd0) ? 64'h1_0000_0000 : (longint'(1) << b);
    return d & 32'(m - 1);
  endfunction

  typedef struct {
    int          ch;
    logic [1:0]  op;
    logic [31:0] fd;
    logic [31:0] addr;
    logic [4:0]  bits;
    logic [31:0] wdata;
    int          k;
    logic [31:0] rd;
    logic        eof;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, e;
    logic [31:0]  d;
    int           waited, edges, hi, model_last, expc;
    bit           ok;
    logic [N-1:0] pending;
    logic [1:0]   r_op[N];
    logic [31:0]  r_fd[N], r_addr[N], r_wd[N];
    logic [4:0]   r_bits[N];
    logic [31:0]  rd;
    logic         eof;
    int           k;

    vecs[0] = '{0, 2'b00, 32'd3,   32'h10,   5'd0,  32'h0,        0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3};
    vecs[1] = '{1, 2'b00, 32'd4,   32'h20,   5'd8,  32'h0,        0, 32'h12345678, 1'b0, 32'h00000078, 3};
    vecs[2] = '{2, 2'b00, 32'd5,   32'h30,   5'd0,  32'h0,        0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 3};
    vecs[3] = '{3, 2'b01, 32'd6,   32'h40,   5'd0,  32'hCAFEF00D, 2, 32'h11111111, 1'b0, 32'h00000000, 5};
    vecs[4] = '{0, 2'b10, 32'd7,   32'h50,   5'd0,  32'h0,        0, 32'h22222222, 1'b0, 32'h00000000, 3};
    vecs[5] = '{1, 2'b11, 32'd8,   32'h60,   5'd4,  32'h0,        1, 32'h33333333, 1'b0, 32'h00000000, 4};
    vecs[6] = '{2, 2'b00, 32'd9,   32'h70,   5'd31, 32'h0,        0, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 3};
    vecs[7] = '{3, 2'b00, 32'd10,  32'h80,   5'd1,  32'h0,        0, 32'h00000003, 1'b0, 32'h00000001, 3};
    vecs[8] = '{0, 2'b00, 32'd11,  32'h90,   5'd16, 32'h0,        3, 32'hABCD1234, 1'b0, 32'h00001234, 6};

    rst_n = 1'b0; req = '0; op = '0; fd = '0; addr = '0; bits = '0; wdata = '0;
    be_ready = 1'b0; be_rdata = '0; be_eof = 1'b0;

    // Reset state, with every client already requesting.
    for (int c = 0; c < N; c++) set_client(c, 2'b00, 32'(100 + c), 32'(c), 5'd0, 32'h0);
    req = '1;
    repeat (3) @(negedge clk);
    check("reset_be_valid", 64'(be_valid), 64'd0);
    check("reset_be_fields", {be_op, be_bits, be_fd}, 64'd0);
    check("reset_be_addr_wdata", {be_addr, be_wdata}, 64'd0);
    check("reset_ack_err", {ack, err}, 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;

    // Round-robin with continuous requests: 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      wait_valid(waited, ok);
      check($sformatf("rr_valid_%0d", t), 64'(ok), 64'd1);
      check($sformatf("rr_grant_fd_%0d", t), 64'(be_fd), 64'(100 + (t % N)));
      serve(0, 32'h0, 1'b0, a, e, d, edges);
      check($sformatf("rr_ack_%0d", t), 64'(a), 64'(1 << (t % N)));
    end
    req = '0;

    // Vector table, one client at a time.
    for (int v = 0; v < 9; v++) begin
      set_client(vecs[v].ch, vecs[v].op, vecs[v].fd, vecs[v].addr, vecs[v].bits, vecs[v].wdata);
      req[vecs[v].ch] = 1'b1;
      wait_valid(waited, ok);
      check($sformatf("vec%0d_be_fields", v), {be_op, be_bits, be_fd},
            {vecs[v].op, vecs[v].bits, vecs[v].fd});
      check($sformatf("vec%0d_be_addr_wdata", v), {be_addr, be_wdata}, {vecs[v].addr, vecs[v].wdata});
      serve(vecs[v].k, vecs[v].rd, vecs[v].eof, a, e, d, edges);
      req[vecs[v].ch] = 1'b0;
      check($sformatf("vec%0d_ack", v), 64'(a), 64'(1 << vecs[v].ch));
      check($sformatf("vec%0d_err", v), 64'(e), 64'd0);
      check($sformatf("vec%0d_rdata", v), 64'(d), 64'(vecs[v].exp_rd));
      check($sformatf("vec%0d_latency", v), 64'(waited + edges), 64'(vecs[v].exp_lat));
      @(negedge clk);
      check($sformatf("vec%0d_ack_pulse", v), 64'(ack), 64'd0);
    end

    // Timeout: backend never answers.
    set_client(1, 2'b00, 32'd21, 32'h100, 5'd0, 32'h0);
    req[1] = 1'b1;
    wait_valid(waited, ok);
    hi = 1; edges = 0; a = '0; e = '0; d = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (be_valid) hi++;
      if (ack != '0) begin
        edges = i + 1; a = ack; e = err; d = rdata;
        break;
      end
    end
    req[1] = 1'b0;
    check("timeout_valid_cycles", 64'(hi), 64'(TO));
    check("timeout_ack_edges", 64'(edges), 64'(TO + 1));
    check("timeout_ack", 64'(a), 64'b0010);
    check("timeout_err", 64'(e), 64'b0010);
    check("timeout_rdata", 64'(d), 64'd0);
    @(negedge clk);
    check("timeout_valid_after", 64'(be_valid), 64'd0);

    // Race: be_ready sampled on the edge where the timeout would fire.
    set_client(3, 2'b00, 32'd22, 32'h200, 5'd0, 32'h0);
    req[3] = 1'b1;
    wait_valid(waited, ok);
    serve(TO - 1, 32'h5A5A0F0F, 1'b0, a, e, d, edges);
    req[3] = 1'b0;
    check("race_ack", 64'(a), 64'b1000);
    check("race_err", 64'(e), 64'd0);
    check("race_rdata", 64'(d), 64'h5A5A0F0F);
    check("race_ack_edges", 64'(edges), 64'(TO + 1));

    // Move the pointer to 3, then reset in the middle of ISSUE.
    set_client(2, 2'b00, 32'd32, 32'h0, 5'd0, 32'h0);
    req[2] = 1'b1;
    wait_valid(waited, ok);
    serve(0, 32'h1, 1'b0, a, e, d, edges);
    req[2] = 1'b0;
    check("pre_reset_ack", 64'(a), 64'b0100);
    @(negedge clk);
    req[2] = 1'b1;
    wait_valid(waited, ok);
    check("pre_reset_valid", 64'(be_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("reset_async_valid", 64'(be_valid), 64'd0);
    check("reset_async_fd", 64'(be_fd), 64'd0);
    set_client(1, 2'b00, 32'd31, 32'h0, 5'd0, 32'h0);
    set_client(3, 2'b00, 32'd33, 32'h0, 5'd0, 32'h0);
    req = 4'b1110;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack != '0) hi++;
    end
    check("reset_no_ack", 64'(hi), 64'd0);
    rst_n = 1'b1;
    wait_valid(waited, ok);
    check("post_reset_grant", 64'(be_fd), 64'd31);
    serve(0, 32'h77, 1'b0, a, e, d, edges);
    req = '0;
    check("post_reset_ack", 64'(a), 64'b0010);

    // Randomized batches against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    for (int it = 0; it < 40; it++) begin
      pending = 4'($urandom_range(1, 15));
      for (int c = 0; c < N; c++) begin
        r_op[c] = 2'($urandom_range(0, 3)); r_fd[c] = $urandom; r_addr[c] = $urandom;
        r_bits[c] = 5'($urandom_range(0, 31)); r_wd[c] = $urandom;
        set_client(c, r_op[c], r_fd[c], r_addr[c], r_bits[c], r_wd[c]);
      end
      req = pending;
      for (int s = 0; s < N && pending != '0; s++) begin
        expc = -1;
        for (int dd = 1; dd <= N; dd++)
          if (expc < 0 && pending[(model_last + dd) % N]) expc = (model_last + dd) % N;
        wait_valid(waited, ok);
        check("rand_valid", 64'(ok), 64'd1);
        if (!ok) break;
        // Client changes its fields after grant; the backend command must not follow.
        set_client(expc, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom);
        k = $urandom_range(0, 4);
        rd = $urandom;
        eof = ($urandom_range(0, 3) == 0);
        serve(k, rd, eof, a, e, d, edges);
        req[expc] = 1'b0;
        pending[expc] = 1'b0;
        model_last = expc;
        check("rand_ack", 64'(a), 64'(1 << expc));
        check("rand_err", 64'(e), 64'd0);
        check("rand_rdata", 64'(d), 64'(model_rdata(r_op[expc], r_bits[expc], rd, eof)));
        check("rand_be_fields", {be_op, be_bits, be_fd}, {r_op[expc], r_bits[expc], r_fd[expc]});
        check("rand_be_addr_wdata", {be_addr, be_wdata}, {r_addr[expc], r_wd[expc]});
      end
      req = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
